// File: rtl/rf_iterator_if.sv
// Host command, descriptor-table and response signals of the reflection object iterator.
// The slave modport is the iterator itself; the master modport is its environment.
interface rf_iterator_if #(
  parameter int HANDLE_W = 8,
  parameter int KIND_W   = 4,
  parameter int ITER_W   = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [HANDLE_W-1:0] cmd_parent;
  logic [KIND_W-1:0]   cmd_kind;
  logic [ITER_W-1:0]   cmd_iter;

  logic                tbl_rd_en;
  logic [HANDLE_W-1:0] tbl_rd_addr;
  logic [HANDLE_W-1:0] tbl_rd_parent;
  logic [KIND_W-1:0]   tbl_rd_kind;
  logic                tbl_rd_vld;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_status;
  logic [HANDLE_W-1:0] rsp_handle;
  logic [ITER_W-1:0]   rsp_iter;

  modport slave (
    input  cmd_valid, cmd_op, cmd_parent, cmd_kind, cmd_iter,
    output cmd_ready,
    output tbl_rd_en, tbl_rd_addr,
    input  tbl_rd_parent, tbl_rd_kind, tbl_rd_vld,
    output rsp_valid, rsp_status, rsp_handle, rsp_iter,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_parent, cmd_kind, cmd_iter,
    input  cmd_ready,
    input  tbl_rd_en, tbl_rd_addr,
    output tbl_rd_parent, tbl_rd_kind, tbl_rd_vld,
    input  rsp_valid, rsp_status, rsp_handle, rsp_iter,
    output rsp_ready
  );
endinterface

// File: rtl/rf_iterator.sv
// Multi-slot descriptor-table iterator returning matching child handles one per SCAN.
// Define RF_ITER_KIND_WILDCARD_EN to make an iterator kind filter of 0 match any entry kind.
module rf_iterator #(
  parameter int HANDLE_W = 8,
  parameter int DEPTH    = 256,
  parameter int KIND_W   = 4,
  parameter int NUM_ITER = 4,
  parameter int ITER_W   = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1
) (
  input  logic clk,
  input  logic rst_n,
  rf_iterator_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP} state_e;

  localparam logic [1:0] OP_ITERATE = 2'd0;
  localparam logic [1:0] OP_SCAN    = 2'd1;
  localparam logic [1:0] OP_FREE    = 2'd2;
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_END     = 2'd1;
  localparam logic [1:0] ST_ERR     = 2'd2;
  localparam logic [HANDLE_W-1:0] LAST_IDX = HANDLE_W'(DEPTH - 1);

  state_e state_q, state_d;
  logic   running_q;

  logic [NUM_ITER-1:0]               alloc_q, alloc_d;
  logic [NUM_ITER-1:0][HANDLE_W-1:0] parent_q, parent_d;
  logic [NUM_ITER-1:0][KIND_W-1:0]   kind_q, kind_d;
  logic [NUM_ITER-1:0][HANDLE_W-1:0] cursor_q, cursor_d;

  logic [ITER_W-1:0]   slot_q, slot_d;
  logic [HANDLE_W-1:0] rdAddr_q, rdAddr_d;
  logic [HANDLE_W-1:0] cmpIdx_q, cmpIdx_d;
  logic                cmpVld_q, cmpVld_d;
  logic                issueDone_q, issueDone_d;

  logic                rspValid_q, rspValid_d;
  logic [1:0]          rspStatus_q, rspStatus_d;
  logic [HANDLE_W-1:0] rspHandle_q, rspHandle_d;
  logic [ITER_W-1:0]   rspIter_q, rspIter_d;

  logic              freeFound;
  logic [ITER_W-1:0] freeIdx;
  logic              iterInRange;
  logic              kindHit;
  logic              entryMatch;

  always_comb begin
    state_d     = state_q;
    alloc_d     = alloc_q;
    parent_d    = parent_q;
    kind_d      = kind_q;
    cursor_d    = cursor_q;
    slot_d      = slot_q;
    rdAddr_d    = rdAddr_q;
    cmpIdx_d    = cmpIdx_q;
    cmpVld_d    = cmpVld_q;
    issueDone_d = issueDone_q;
    rspValid_d  = rspValid_q;
    rspStatus_d = rspStatus_q;
    rspHandle_d = rspHandle_q;
    rspIter_d   = rspIter_q;

    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = NUM_ITER - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        freeFound = 1'b1;
        freeIdx   = ITER_W'(i);
      end
    end
    iterInRange = int'(bus.cmd_iter) < NUM_ITER;

`ifdef RF_ITER_KIND_WILDCARD_EN
    kindHit = (bus.tbl_rd_kind == kind_q[slot_q]) || (kind_q[slot_q] == '0);
`else
    kindHit = (bus.tbl_rd_kind == kind_q[slot_q]);
`endif
    entryMatch = bus.tbl_rd_vld && (bus.tbl_rd_parent == parent_q[slot_q]) && kindHit;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && running_q) begin
          state_d     = S_RESP;
          rspValid_d  = 1'b1;
          rspStatus_d = ST_OK;
          rspHandle_d = '0;
          rspIter_d   = bus.cmd_iter;
          unique case (bus.cmd_op)
            OP_ITERATE: begin
              if (freeFound) begin
                alloc_d[freeIdx]  = 1'b1;
                parent_d[freeIdx] = bus.cmd_parent;
                kind_d[freeIdx]   = bus.cmd_kind;
                cursor_d[freeIdx] = '0;
                rspIter_d         = freeIdx;
              end else begin
                rspStatus_d = ST_ERR;
                rspIter_d   = '0;
              end
            end
            OP_SCAN: begin
              if (!iterInRange) begin
                rspStatus_d = ST_ERR;
              end else if (!alloc_q[bus.cmd_iter]) begin
                rspStatus_d = ST_ERR;
              end else if (cursor_q[bus.cmd_iter] == LAST_IDX) begin
                rspStatus_d            = ST_END;
                alloc_d[bus.cmd_iter]  = 1'b0;
              end else begin
                // Prime the walk; the response is built when a match or the last entry is seen.
                state_d     = S_WALK;
                rspValid_d  = 1'b0;
                slot_d      = bus.cmd_iter;
                rdAddr_d    = cursor_q[bus.cmd_iter] + 1'b1;
                cmpVld_d    = 1'b0;
                issueDone_d = 1'b0;
              end
            end
            OP_FREE: begin
              if (iterInRange) alloc_d[bus.cmd_iter] = 1'b0;
            end
            default: rspStatus_d = ST_ERR;
          endcase
        end
      end

      S_WALK: begin
        if (!issueDone_q) begin
          cmpVld_d = 1'b1;
          cmpIdx_d = rdAddr_q;
          if (rdAddr_q == LAST_IDX) issueDone_d = 1'b1;
          else                      rdAddr_d    = rdAddr_q + 1'b1;
        end else begin
          cmpVld_d = 1'b0;
        end
        // A match wins over the read issued this cycle, which is simply dropped.
        if (cmpVld_q) begin
          if (entryMatch) begin
            state_d          = S_RESP;
            rspValid_d       = 1'b1;
            rspStatus_d      = ST_OK;
            rspHandle_d      = cmpIdx_q;
            rspIter_d        = slot_q;
            cursor_d[slot_q] = cmpIdx_q;
          end else if (cmpIdx_q == LAST_IDX) begin
            state_d         = S_RESP;
            rspValid_d      = 1'b1;
            rspStatus_d     = ST_END;
            rspHandle_d     = '0;
            rspIter_d       = slot_q;
            alloc_d[slot_q] = 1'b0;
          end
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      running_q   <= 1'b0;
      alloc_q     <= '0;
      parent_q    <= '0;
      kind_q      <= '0;
      cursor_q    <= '0;
      slot_q      <= '0;
      rdAddr_q    <= '0;
      cmpIdx_q    <= '0;
      cmpVld_q    <= 1'b0;
      issueDone_q <= 1'b0;
      rspValid_q  <= 1'b0;
      rspStatus_q <= '0;
      rspHandle_q <= '0;
      rspIter_q   <= '0;
    end else begin
      state_q     <= state_d;
      running_q   <= 1'b1;
      alloc_q     <= alloc_d;
      parent_q    <= parent_d;
      kind_q      <= kind_d;
      cursor_q    <= cursor_d;
      slot_q      <= slot_d;
      rdAddr_q    <= rdAddr_d;
      cmpIdx_q    <= cmpIdx_d;
      cmpVld_q    <= cmpVld_d;
      issueDone_q <= issueDone_d;
      rspValid_q  <= rspValid_d;
      rspStatus_q <= rspStatus_d;
      rspHandle_q <= rspHandle_d;
      rspIter_q   <= rspIter_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE) && running_q;
  assign bus.tbl_rd_en   = (state_q == S_WALK) && !issueDone_q;
  assign bus.tbl_rd_addr = bus.tbl_rd_en ? rdAddr_q : '0;
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_status  = rspStatus_q;
  assign bus.rsp_handle  = rspHandle_q;
  assign bus.rsp_iter    = rspIter_q;

endmodule

// File: tb/tb_rf_iterator.sv
// Scoreboard bench for rf_iterator with a 16-entry descriptor table and 4 iterator slots.
// Expected responses are queued at command acceptance and checked by an independent monitor.
module tb_rf_iterator;

  localparam int HW = 8;
  localparam int KW = 4;
  localparam int IW = 2;

  localparam int OP_ITERATE = 0;
  localparam int OP_SCAN    = 1;
  localparam int OP_FREE    = 2;
  localparam int OP_RSVD    = 3;
  localparam int ST_OK      = 0;
  localparam int ST_END     = 1;
  localparam int ST_ERR     = 2;

  typedef struct {
    int status;
    int handle;
    int iter;
    int lat;
    int acceptCycle;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int   cycleCnt = 0;
  int   total    = 0;
  int   bad      = 0;
  int   rspDone  = 0;
  bit   inRsp    = 1'b0;
  exp_t cur;
  exp_t expQ[$];

  logic [HW-1:0] memParent [16];
  logic [KW-1:0] memKind   [16];
  logic          memVld    [16];

  rf_iterator_if #(.HANDLE_W(HW), .KIND_W(KW), .ITER_W(IW)) bus ();

  rf_iterator #(
    .HANDLE_W(HW), .DEPTH(16), .KIND_W(KW), .NUM_ITER(4), .ITER_W(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Descriptor memory with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.tbl_rd_en && bus.tbl_rd_addr[HW-1:4] == '0) begin
      bus.tbl_rd_parent <= memParent[bus.tbl_rd_addr[3:0]];
      bus.tbl_rd_kind   <= memKind[bus.tbl_rd_addr[3:0]];
      bus.tbl_rd_vld    <= memVld[bus.tbl_rd_addr[3:0]];
    end else begin
      bus.tbl_rd_parent <= '0;
      bus.tbl_rd_kind   <= '0;
      bus.tbl_rd_vld    <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Monitor: pops one expectation per response and rechecks it every cycle it is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      inRsp = 1'b0;
    end else if (bus.rsp_valid) begin
      if (!inRsp) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRsp", int'(bus.rsp_valid), 0);
        end else begin
          cur   = expQ.pop_front();
          inRsp = 1'b1;
          checkOutput("rspLatency", cycleCnt - cur.acceptCycle, cur.lat);
        end
      end
      if (inRsp) begin
        checkOutput("rspStatus", int'(bus.rsp_status), cur.status);
        checkOutput("rspHandle", int'(bus.rsp_handle), cur.handle);
        checkOutput("rspIter",   int'(bus.rsp_iter),   cur.iter);
        if (bus.rsp_ready) begin
          inRsp = 1'b0;
          rspDone++;
        end
      end
    end
  end

  task automatic applyStimulus(input int op, input int parent, input int kind, input int iter,
                               input int expStatus, input int expHandle, input int expIter,
                               input int expLat, input bit waitRsp);
    int   n;
    int   target;
    exp_t e;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 2'(op);
    bus.cmd_parent = HW'(parent);
    bus.cmd_kind   = KW'(kind);
    bus.cmd_iter   = IW'(iter);
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checkOutput("cmdAccept", int'(bus.cmd_ready), 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    e.status      = expStatus;
    e.handle      = expHandle;
    e.iter        = expIter;
    e.lat         = expLat;
    e.acceptCycle = cycleCnt;
    expQ.push_back(e);
    target = rspDone + 1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    if (waitRsp) begin
      n = 0;
      while (rspDone < target && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (rspDone < target) checkOutput("rspTimeout", rspDone, target);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      memParent[i] = '0;
      memKind[i]   = '0;
      memVld[i]    = 1'b0;
    end
    memParent[0]  = 8'd5; memKind[0]  = 4'd2; memVld[0]  = 1'b1;
    memParent[2]  = 8'd9; memKind[2]  = 4'd1; memVld[2]  = 1'b1;
    memParent[3]  = 8'd5; memKind[3]  = 4'd2; memVld[3]  = 1'b1;
    memParent[4]  = 8'd1; memKind[4]  = 4'd4; memVld[4]  = 1'b1;
    memParent[7]  = 8'd5; memKind[7]  = 4'd2; memVld[7]  = 1'b1;
    memParent[8]  = 8'd5; memKind[8]  = 4'd3; memVld[8]  = 1'b1;
    memParent[9]  = 8'd6; memKind[9]  = 4'd2; memVld[9]  = 1'b1;
    memParent[10] = 8'd9; memKind[10] = 4'd1; memVld[10] = 1'b1;
    memParent[11] = 8'd5; memKind[11] = 4'd2; memVld[11] = 1'b0;
    memParent[12] = 8'd5; memKind[12] = 4'd2; memVld[12] = 1'b1;
    memParent[15] = 8'd9; memKind[15] = 4'd1; memVld[15] = 1'b1;

    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_parent = '0;
    bus.cmd_kind   = '0;
    bus.cmd_iter   = '0;
    bus.rsp_ready  = 1'b1;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetCmdReady",  int'(bus.cmd_ready),   0);
    checkOutput("resetRspValid",  int'(bus.rsp_valid),   0);
    checkOutput("resetRspStatus", int'(bus.rsp_status),  0);
    checkOutput("resetRspHandle", int'(bus.rsp_handle),  0);
    checkOutput("resetRspIter",   int'(bus.rsp_iter),    0);
    checkOutput("resetRdEn",      int'(bus.tbl_rd_en),   0);
    checkOutput("resetRdAddr",    int'(bus.tbl_rd_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", int'(bus.cmd_ready), 1);

    $display("[TB] single iterator walk over parent 5 kind 2");
    applyStimulus(OP_ITERATE, 5, 2, 0, ST_OK,  0,  0, 1, 1);
    applyStimulus(OP_SCAN,    0, 0, 0, ST_OK,  3,  0, 5, 1);
    applyStimulus(OP_SCAN,    0, 0, 0, ST_OK,  7,  0, 6, 1);
    applyStimulus(OP_SCAN,    0, 0, 0, ST_OK,  12, 0, 7, 1);
    applyStimulus(OP_SCAN,    0, 0, 0, ST_END, 0,  0, 5, 1);
    applyStimulus(OP_SCAN,    0, 0, 0, ST_ERR, 0,  0, 1, 1);

    $display("[TB] slot allocation and exhaustion");
    applyStimulus(OP_ITERATE, 9, 1, 0, ST_OK,  0, 0, 1, 1);
    applyStimulus(OP_ITERATE, 5, 2, 0, ST_OK,  0, 1, 1, 1);
    applyStimulus(OP_ITERATE, 7, 7, 0, ST_OK,  0, 2, 1, 1);
    applyStimulus(OP_ITERATE, 6, 2, 0, ST_OK,  0, 3, 1, 1);
    applyStimulus(OP_ITERATE, 5, 2, 0, ST_ERR, 0, 0, 1, 1);
    applyStimulus(OP_FREE,    0, 0, 2, ST_OK,  0, 2, 1, 1);
    applyStimulus(OP_ITERATE, 1, 0, 0, ST_OK,  0, 2, 1, 1);

    $display("[TB] interleaved iterators");
    applyStimulus(OP_SCAN, 0, 0, 0, ST_OK,  2,  0, 4,  1);
    applyStimulus(OP_SCAN, 0, 0, 1, ST_OK,  3,  1, 5,  1);
    applyStimulus(OP_SCAN, 0, 0, 0, ST_OK,  10, 0, 10, 1);
    applyStimulus(OP_SCAN, 0, 0, 1, ST_OK,  7,  1, 6,  1);
    applyStimulus(OP_SCAN, 0, 0, 0, ST_OK,  15, 0, 7,  1);
    applyStimulus(OP_SCAN, 0, 0, 0, ST_END, 0,  0, 1,  1);
    applyStimulus(OP_SCAN, 0, 0, 3, ST_OK,  9,  3, 11, 1);

    $display("[TB] kind filter 0 under parent 1");
`ifdef RF_ITER_KIND_WILDCARD_EN
    applyStimulus(OP_SCAN, 0, 0, 2, ST_OK,  4, 2, 6,  1);
`else
    applyStimulus(OP_SCAN, 0, 0, 2, ST_END, 0, 2, 17, 1);
`endif
    applyStimulus(OP_FREE, 0, 0, 2, ST_OK,  0, 2, 1, 1);
    applyStimulus(OP_FREE, 0, 0, 2, ST_OK,  0, 2, 1, 1);
    applyStimulus(OP_RSVD, 0, 0, 0, ST_ERR, 0, 0, 1, 1);

    $display("[TB] response held with rsp_ready low");
    bus.rsp_ready = 1'b0;
    applyStimulus(OP_SCAN, 0, 0, 1, ST_OK, 12, 1, 7, 0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("holdRspValidSeen", int'(bus.rsp_valid), 1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("holdCmdReady", int'(bus.cmd_ready), 0);
      checkOutput("holdRspValid", int'(bus.rsp_valid), 1);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("readyAfterHandshake", int'(bus.cmd_ready), 1);
    checkOutput("validAfterHandshake", int'(bus.rsp_valid), 0);
    applyStimulus(OP_FREE, 0, 0, 1, ST_OK, 0, 1, 1, 1);

    $display("[TB] reset during a walk");
    applyStimulus(OP_ITERATE, 7, 7, 0, ST_OK,  0, 0, 1,  1);
    applyStimulus(OP_SCAN,    0, 0, 0, ST_END, 0, 0, 17, 0);
    repeat (5) @(negedge clk);
    checkOutput("midWalkRdEn", int'(bus.tbl_rd_en), 1);
    #1 rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abortRspValid", int'(bus.rsp_valid),   0);
    checkOutput("abortCmdReady", int'(bus.cmd_ready),   0);
    checkOutput("abortRdEn",     int'(bus.tbl_rd_en),   0);
    checkOutput("abortRdAddr",   int'(bus.tbl_rd_addr), 0);
    repeat (2) @(negedge clk);
    checkOutput("abortRspValidHeld", int'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterAbort", int'(bus.cmd_ready), 1);
    applyStimulus(OP_SCAN,    0, 0, 0, ST_ERR, 0, 0, 1, 1);
    applyStimulus(OP_SCAN,    0, 0, 3, ST_ERR, 0, 3, 1, 1);
    applyStimulus(OP_ITERATE, 5, 2, 0, ST_OK,  0, 0, 1, 1);

    repeat (3) @(negedge clk);
    checkOutput("pendingRsp", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
